regfile_access_sequencer: RTL and testbench
===========================================

# regfile_access_sequencer

Initiator-side front end for the core's 32 x 32-bit register file. It clears every register after reset, then serves the core through two handshakes. Operand reads return three source operands one cycle after acceptance, with x0 forced to zero and same-cycle writeback bypass. Writebacks go straight to the file's single write port. It sits between the core's decode/writeback stages and the register file's select/data ports.

## Interface
- num_registers, 32, number of registers cleared at init; select width fixed at 5 bits
- init_value, 32'h0, value written to every register during init
- CLK  input  1  clock, all state on rising edge
- RESET  input  1  asynchronous, active-high reset
- in_req_valid  input  1  operand request valid
- out_req_ready  output  1  request accepted when valid & ready
- in_req_rs0 / in_req_rs1 / in_req_rs2  input  5 each  source register indices
- out_rsp_valid  output  1  operand response valid
- in_rsp_ready  input  1  consumer accepts response
- out_rsp_data_0 / _1 / _2  output  32 each  operand values
- in_wb_valid  input  1  writeback valid
- out_wb_ready  output  1  writeback accepted when valid & ready
- in_wb_rd  input  5  destination index
- in_wb_data  input  32  writeback value
- out_write_enable  output  1  to register file write enable
- out_write_register_select  output  5  to register file write index
- out_write_data  output  32  to register file write data
- out_read_register_select_0 / _1 / _2  output  5 each  to register file read indices
- in_read_data_0 / _1 / _2  input  32 each  combinational read data from register file
- out_init_done  output  1  high once init sweep complete

## Operation
- FSM states: INIT, RUN. RESET forces INIT and init counter 0.
- INIT behaviour:
  - each cycle drive out_write_enable=1, select=counter, data=init_value, then counter++.
  - After the write at counter num_registers-1, go to RUN.
  - out_req_ready=0 and out_wb_ready=0 throughout INIT.
- RUN behaviour:
  - out_wb_ready=1.
  - out_write_enable = in_wb_valid & (in_wb_rd != 0); select/data pass through from in_wb_rd/in_wb_data.
  - A write to x0 is accepted and dropped.
- Read pipeline:
  - out_read_register_select_N = in_req_rsN (combinational, always driven).
  - out_req_ready = RUN & (!out_rsp_valid | in_rsp_ready).
  - On acceptance, per operand N the response register captures one of:
    - 0 if rsN==0;
    - in_wb_data if a writeback is accepted in the same cycle with in_wb_rd==rsN!=0 (bypass);
    - otherwise in_read_data_N.
  - Then out_rsp_valid=1.
- Response lifetime:
  - out_rsp_valid clears on in_rsp_ready with no new acceptance.
  - Back-to-back acceptance keeps valid high and loads new data.
  - The response is a snapshot. Writebacks after capture do not update a held response.
- Duplicate indices (rs0==rs1 etc.) are legal; each operand resolves independently.

## Timing
- Reset values:
  - out_rsp_valid=0, out_rsp_data_*=0, out_init_done=0, out_req_ready=0, out_wb_ready=0.
  - out_write_enable=0 while RESET is high.
- Init duration:
  - Init writes occur on the num_registers cycles following RESET deassertion.
  - out_init_done and RUN are effective in the next cycle: cycle num_registers+1, counting the first post-reset cycle as 1.
- Read latency: 1 cycle. A request accepted at edge k gives out_rsp_valid=1 with data after edge k.
- Backpressure: while out_rsp_valid & !in_rsp_ready, out_rsp_data_* are held stable and out_req_ready=0.
- Write latency: the register file updates at the edge the writeback is accepted. A read requested in the next cycle sees it without bypass.
- Reset mid-operation (INIT or RUN):
  - all state clears immediately and the sweep restarts from register 0;
  - any pending response is discarded.

## Test plan
- Init sweep: release RESET; check 32 consecutive writes of 0 to indices 0..31, out_init_done rising in the following cycle, and both readies low until then.
- Write then read: wb rd=5 data=32'hDEADBEEF; next cycle request rs0=5,rs1=0,rs2=5 -> response one cycle later = DEADBEEF, 0, DEADBEEF.
- Same-cycle bypass: request rs1=7 in the same cycle as wb rd=7 data=32'h12345678 -> out_rsp_data_1=12345678 (not the stale value).
- x0 handling:
  - wb rd=0 data=32'hFFFFFFFF -> out_write_enable stays 0;
  - a subsequent read of rs0=0 -> 0.
- Backpressure: hold in_rsp_ready=0 for 3 cycles after a response -> data stable, out_req_ready=0. A write to the same register meanwhile does not change the held data. Release -> next request is accepted.
- Reset mid-init: assert RESET at counter=10 -> outputs return to reset values. On release the sweep restarts at index 0 and completes all 32 writes.

Source files
------------

// File: rtl/regfile_access_sequencer_if.sv
// ============================================================================
// Module      : regfile_access_sequencer_if
// Description : Core-side handshakes and register-file port bundle for the
//               register-file access sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_access_sequencer_if;
    logic        in_req_valid;
    logic        out_req_ready;
    logic [4:0]  in_req_rs0;
    logic [4:0]  in_req_rs1;
    logic [4:0]  in_req_rs2;
    logic        out_rsp_valid;
    logic        in_rsp_ready;
    logic [31:0] out_rsp_data_0;
    logic [31:0] out_rsp_data_1;
    logic [31:0] out_rsp_data_2;
    logic        in_wb_valid;
    logic        out_wb_ready;
    logic [4:0]  in_wb_rd;
    logic [31:0] in_wb_data;
    logic        out_write_enable;
    logic [4:0]  out_write_register_select;
    logic [31:0] out_write_data;
    logic [4:0]  out_read_register_select_0;
    logic [4:0]  out_read_register_select_1;
    logic [4:0]  out_read_register_select_2;
    logic [31:0] in_read_data_0;
    logic [31:0] in_read_data_1;
    logic [31:0] in_read_data_2;
    logic        out_init_done;

    modport slave (
        input  in_req_valid, in_req_rs0, in_req_rs1, in_req_rs2, in_rsp_ready,
               in_wb_valid, in_wb_rd, in_wb_data,
               in_read_data_0, in_read_data_1, in_read_data_2,
        output out_req_ready, out_rsp_valid,
               out_rsp_data_0, out_rsp_data_1, out_rsp_data_2,
               out_wb_ready, out_write_enable, out_write_register_select, out_write_data,
               out_read_register_select_0, out_read_register_select_1,
               out_read_register_select_2, out_init_done
    );

    modport master (
        output in_req_valid, in_req_rs0, in_req_rs1, in_req_rs2, in_rsp_ready,
               in_wb_valid, in_wb_rd, in_wb_data,
               in_read_data_0, in_read_data_1, in_read_data_2,
        input  out_req_ready, out_rsp_valid,
               out_rsp_data_0, out_rsp_data_1, out_rsp_data_2,
               out_wb_ready, out_write_enable, out_write_register_select, out_write_data,
               out_read_register_select_0, out_read_register_select_1,
               out_read_register_select_2, out_init_done
    );
endinterface

`default_nettype wire

// File: rtl/regfile_access_sequencer.sv
// ============================================================================
// Module      : regfile_access_sequencer
// Description : Clears the 32x32 register file after reset, then serves
//               operand reads (x0 = 0, writeback bypass) and writebacks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_access_sequencer #(
    parameter int          NUM_REGISTERS = 32,
    parameter logic [31:0] INIT_VALUE    = 32'h0
) (
    input  wire logic                   CLK,
    input  wire logic                   RESET,
    regfile_access_sequencer_if.slave   bus
);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [4:0] c_last_reg = 5'(NUM_REGISTERS - 1);

    state_t      r_state;
    logic [4:0]  r_init_cnt;
    logic        r_init_done;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data_0;
    logic [31:0] r_rsp_data_1;
    logic [31:0] r_rsp_data_2;

    logic        w_run;
    logic        w_req_ready;
    logic        w_accept;
    logic        w_wb_accept;

    assign w_run       = (r_state == S_RUN);
    assign w_req_ready = w_run & (~r_rsp_valid | bus.in_rsp_ready);
    assign w_accept    = bus.in_req_valid & w_req_ready;
    assign w_wb_accept = bus.in_wb_valid & w_run;

    // Operand value seen by a request accepted this cycle: a writeback landing
    // on the same edge is not yet visible on the file's read port.
    function automatic logic [31:0] resolve(
        input logic [4:0]  rs,
        input logic [31:0] file_data,
        input logic        wb_hit,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_data
    );
        if (rs == 5'd0)
            return 32'h0;
        else if (wb_hit && (wb_rd == rs))
            return wb_data;
        else
            return file_data;
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= S_INIT;
            r_init_cnt   <= 5'd0;
            r_init_done  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data_0 <= 32'h0;
            r_rsp_data_1 <= 32'h0;
            r_rsp_data_2 <= 32'h0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_init_cnt <= r_init_cnt + 5'd1;
                    if (r_init_cnt == c_last_reg) begin
                        r_state     <= S_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_data_0 <= resolve(bus.in_req_rs0, bus.in_read_data_0,
                                                w_wb_accept, bus.in_wb_rd, bus.in_wb_data);
                        r_rsp_data_1 <= resolve(bus.in_req_rs1, bus.in_read_data_1,
                                                w_wb_accept, bus.in_wb_rd, bus.in_wb_data);
                        r_rsp_data_2 <= resolve(bus.in_req_rs2, bus.in_read_data_2,
                                                w_wb_accept, bus.in_wb_rd, bus.in_wb_data);
                    end else if (bus.in_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign bus.out_req_ready  = w_req_ready;
    assign bus.out_wb_ready   = w_run;
    assign bus.out_rsp_valid  = r_rsp_valid;
    assign bus.out_rsp_data_0 = r_rsp_data_0;
    assign bus.out_rsp_data_1 = r_rsp_data_1;
    assign bus.out_rsp_data_2 = r_rsp_data_2;
    assign bus.out_init_done  = r_init_done;

    // The sweep write is gated by RESET so nothing reaches the file while held.
    assign bus.out_write_enable          = w_run ? (bus.in_wb_valid & (bus.in_wb_rd != 5'd0))
                                                 : ~RESET;
    assign bus.out_write_register_select = w_run ? bus.in_wb_rd   : r_init_cnt;
    assign bus.out_write_data            = w_run ? bus.in_wb_data : INIT_VALUE;

    assign bus.out_read_register_select_0 = bus.in_req_rs0;
    assign bus.out_read_register_select_1 = bus.in_req_rs1;
    assign bus.out_read_register_select_2 = bus.in_req_rs2;

endmodule

`default_nettype wire

// File: tb/tb_regfile_access_sequencer.sv
// ============================================================================
// Module      : tb_regfile_access_sequencer
// Description : Self-checking bench with a register-file model and an
//               architectural reference model of operand reads/writebacks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_access_sequencer;

    logic CLK;
    logic RESET;
    logic scramble;

    regfile_access_sequencer_if bus_if ();

    regfile_access_sequencer #(
        .NUM_REGISTERS (32),
        .INIT_VALUE    (32'h0)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file behind the sequencer; scramble fills it with garbage so
    // the init sweep is observable.
    logic [31:0] rf [32];
    always @(posedge CLK) begin
        if (scramble) begin
            for (int i = 0; i < 32; i++) rf[i] <= $urandom();
        end else if (bus_if.out_write_enable) begin
            rf[bus_if.out_write_register_select] <= bus_if.out_write_data;
        end
    end
    assign bus_if.in_read_data_0 = rf[bus_if.out_read_register_select_0];
    assign bus_if.in_read_data_1 = rf[bus_if.out_read_register_select_1];
    assign bus_if.in_read_data_2 = rf[bus_if.out_read_register_select_2];

    // Reference model: architectural register values and the expected response.
    logic [31:0] ref_regs [32];
    logic        run_m;
    logic        exp_valid;
    logic [31:0] exp_data [3];

    int checks = 0;
    int errors = 0;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        run_m     = 1'b0;
        exp_valid = 1'b0;
        for (int n = 0; n < 3; n++) exp_data[n] = 32'h0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check(32'(bus_if.out_rsp_valid),    0, {tag, "_rsp_valid"});
        check(bus_if.out_rsp_data_0,        0, {tag, "_rsp_data_0"});
        check(bus_if.out_rsp_data_1,        0, {tag, "_rsp_data_1"});
        check(bus_if.out_rsp_data_2,        0, {tag, "_rsp_data_2"});
        check(32'(bus_if.out_init_done),    0, {tag, "_init_done"});
        check(32'(bus_if.out_req_ready),    0, {tag, "_req_ready"});
        check(32'(bus_if.out_wb_ready),     0, {tag, "_wb_ready"});
        check(32'(bus_if.out_write_enable), 0, {tag, "_write_enable"});
    endtask

    // Enter at posedge+1; walks `count` sweep cycles checking each write.
    task automatic sweep(input int count);
        for (int i = 0; i < count; i++) begin
            bus_if.in_req_valid = 1'b1;
            bus_if.in_req_rs0   = 5'($urandom());
            bus_if.in_req_rs1   = 5'($urandom());
            bus_if.in_req_rs2   = 5'($urandom());
            bus_if.in_rsp_ready = 1'b1;
            bus_if.in_wb_valid  = 1'b1;
            bus_if.in_wb_rd     = 5'd3;
            bus_if.in_wb_data   = $urandom();
            #1;
            check(32'(bus_if.out_write_enable), 1, "init_we");
            check(32'(bus_if.out_write_register_select), i, "init_sel");
            check(bus_if.out_write_data, 32'h0, "init_data");
            check(32'(bus_if.out_req_ready), 0, "init_req_ready");
            check(32'(bus_if.out_wb_ready), 0, "init_wb_ready");
            check(32'(bus_if.out_init_done), 0, "init_done_low");
            @(posedge CLK); #1;
        end
    endtask

    task automatic do_reset();
        RESET    = 1'b1;
        scramble = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("rst");
        @(posedge CLK); #1;
        scramble = 1'b0;
        @(posedge CLK); #1;
        check_reset_outputs("rst_hold");
        RESET = 1'b0;
    endtask

    // One RUN-phase cycle: enter at posedge+1, exit at the next posedge+1.
    task automatic cycle(input logic rv, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] r2, input logic rr, input logic wv,
                         input logic [4:0] wd, input logic [31:0] wdat);
        logic        exp_ready;
        logic        acc;
        logic [4:0]  rs [3];
        logic [31:0] nd [3];
        bus_if.in_req_valid = rv;
        bus_if.in_req_rs0   = r0;
        bus_if.in_req_rs1   = r1;
        bus_if.in_req_rs2   = r2;
        bus_if.in_rsp_ready = rr;
        bus_if.in_wb_valid  = wv;
        bus_if.in_wb_rd     = wd;
        bus_if.in_wb_data   = wdat;
        #1;
        exp_ready = run_m && (!exp_valid || rr);
        check(32'(bus_if.out_req_ready), 32'(exp_ready), "req_ready");
        check(32'(bus_if.out_wb_ready), 32'(run_m), "wb_ready");
        check(32'(bus_if.out_write_enable), 32'(wv && wd != 5'd0), "write_enable");
        if (wv && wd != 5'd0) begin
            check(32'(bus_if.out_write_register_select), 32'(wd), "write_sel");
            check(bus_if.out_write_data, wdat, "write_data");
        end
        check(32'(bus_if.out_read_register_select_1), 32'(r1), "read_sel_1");
        acc = rv && exp_ready;
        rs[0] = r0; rs[1] = r1; rs[2] = r2;
        for (int n = 0; n < 3; n++) begin
            if (rs[n] == 5'd0)                nd[n] = 32'h0;
            else if (wv && wd == rs[n])       nd[n] = wdat;
            else                              nd[n] = ref_regs[rs[n]];
        end
        @(posedge CLK);
        if (acc) begin
            exp_valid = 1'b1;
            for (int n = 0; n < 3; n++) exp_data[n] = nd[n];
        end else if (rr) begin
            exp_valid = 1'b0;
        end
        if (wv && wd != 5'd0) ref_regs[wd] = wdat;
        #1;
        check(32'(bus_if.out_rsp_valid), 32'(exp_valid), "rsp_valid");
        check(bus_if.out_rsp_data_0, exp_data[0], "rsp_data_0");
        check(bus_if.out_rsp_data_1, exp_data[1], "rsp_data_1");
        check(bus_if.out_rsp_data_2, exp_data[2], "rsp_data_2");
    endtask

    initial begin
        RESET = 1'b1;
        scramble = 1'b1;
        bus_if.in_req_valid = 1'b0;
        bus_if.in_req_rs0   = 5'd0;
        bus_if.in_req_rs1   = 5'd0;
        bus_if.in_req_rs2   = 5'd0;
        bus_if.in_rsp_ready = 1'b0;
        bus_if.in_wb_valid  = 1'b0;
        bus_if.in_wb_rd     = 5'd0;
        bus_if.in_wb_data   = 32'h0;
        @(posedge CLK); #1;

        // Reset, partial sweep to counter 10, reset again, then full sweep.
        do_reset();
        sweep(10);
        do_reset();
        sweep(32);
        check(32'(bus_if.out_init_done), 1, "init_done_high");
        for (int i = 0; i < 32; i++) check(rf[i], 32'h0, "rf_cleared");
        run_m = 1'b1;

        // Write then read.
        cycle(0, 0, 0, 0, 1, 1, 5'd5, 32'hDEADBEEF);
        cycle(1, 5, 0, 5, 1, 0, 0, 0);
        check(bus_if.out_rsp_data_0, 32'hDEADBEEF, "wr_rd_0");
        check(bus_if.out_rsp_data_1, 32'h0,        "wr_rd_1");
        check(bus_if.out_rsp_data_2, 32'hDEADBEEF, "wr_rd_2");

        // Same-cycle bypass over a stale value.
        cycle(0, 0, 0, 0, 1, 1, 5'd7, 32'hAAAA0000);
        cycle(1, 0, 7, 0, 1, 1, 5'd7, 32'h12345678);
        check(bus_if.out_rsp_data_1, 32'h12345678, "bypass_1");

        // x0 writes are dropped; x0 reads as zero.
        cycle(0, 0, 0, 0, 1, 1, 5'd0, 32'hFFFFFFFF);
        cycle(1, 0, 0, 0, 1, 0, 0, 0);
        check(bus_if.out_rsp_data_0, 32'h0, "x0_read");

        // Backpressure: held snapshot survives writes to the same register.
        cycle(1, 5, 5, 5, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(1, 5, 7, 0, 0, 1, 5'd5, 32'h0BAD0000 + k);
        check(bus_if.out_rsp_data_0, 32'hDEADBEEF, "bp_held");
        cycle(1, 5, 0, 0, 1, 0, 0, 0);
        check(bus_if.out_rsp_data_0, 32'h0BAD0002, "bp_release");

        // Randomized traffic over a narrow index range to force hazards.
        for (int k = 0; k < 400; k++) begin
            cycle(logic'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  logic'($urandom_range(0, 2) != 0),
                  logic'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
        end
        for (int i = 0; i < 32; i++) check(rf[i], ref_regs[i], "rf_contents");

        // Reset in RUN with a pending response.
        cycle(1, 1, 2, 3, 1, 1, 5'd2, 32'h55AA55AA);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        sweep(32);
        check(32'(bus_if.out_init_done), 1, "reinit_done");
        run_m = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cycle(logic'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
